// File: rtl/processor_pkg.sv
// Shared definitions for the accumulator processor: data/address widths,
// opcode values, FSM state encoding and the two-byte opcode decode.
package processor_pkg;

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned ADDR_W    = 8;
  localparam int unsigned INS_W     = 8;
  localparam int unsigned MEM_DEPTH = 256;

  localparam logic [INS_W-1:0] OP_NOP   = 8'd0;
  localparam logic [INS_W-1:0] OP_LOADI = 8'd1;
  localparam logic [INS_W-1:0] OP_LOAD  = 8'd2;
  localparam logic [INS_W-1:0] OP_STORE = 8'd3;
  localparam logic [INS_W-1:0] OP_MOVR  = 8'd4;
  localparam logic [INS_W-1:0] OP_MOVAC = 8'd5;
  localparam logic [INS_W-1:0] OP_ADD   = 8'd6;
  localparam logic [INS_W-1:0] OP_SUB   = 8'd7;
  localparam logic [INS_W-1:0] OP_MUL   = 8'd8;
  localparam logic [INS_W-1:0] OP_INC   = 8'd9;
  localparam logic [INS_W-1:0] OP_DEC   = 8'd10;
  localparam logic [INS_W-1:0] OP_JMP   = 8'd11;
  localparam logic [INS_W-1:0] OP_JMPZ  = 8'd12;
  localparam logic [INS_W-1:0] OP_JMPNZ = 8'd13;
  localparam logic [INS_W-1:0] OP_ENDOP = 8'd28;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_OPERAND = 2'd1,
    ST_EXEC    = 2'd2,
    ST_HALT    = 2'd3
  } state_e;

  // Opcodes followed by an address/immediate byte.
  function automatic logic is_two_byte(input logic [INS_W-1:0] op);
    case (op)
      OP_LOADI, OP_LOAD, OP_STORE, OP_JMP, OP_JMPZ, OP_JMPNZ: return 1'b1;
      default:                                                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/processor_alu.sv
// Combinational ALU for register-to-accumulator operations.
// Ports: ac_i/r_i operands, op_i opcode; result_c new AC value, zero_c result==0.
// Opcodes it does not handle pass AC through unchanged.
module processor_alu
  import processor_pkg::*;
(
  input  logic [DATA_W-1:0] ac_i,
  input  logic [DATA_W-1:0] r_i,
  input  logic [INS_W-1:0]  op_i,
  output logic [DATA_W-1:0] result_c,
  output logic              zero_c
);

  // All arithmetic wraps modulo 2^16; MUL keeps the low half of the product.
  always_comb begin
    result_c = ac_i;
    case (op_i)
      OP_ADD:   result_c = ac_i + r_i;
      OP_SUB:   result_c = ac_i - r_i;
      OP_MUL:   result_c = ac_i * r_i;
      OP_INC:   result_c = ac_i + DATA_W'(1);
      OP_DEC:   result_c = ac_i - DATA_W'(1);
      OP_MOVAC: result_c = r_i;
      default:  result_c = ac_i;
    endcase
    zero_c = (result_c == '0);
  end

endmodule

// File: rtl/processor.sv
// Multi-cycle accumulator processor: FETCH -> [OPERAND] -> EXEC, ENDOP -> HALT.
// Ports: clk, rst_n (async active-low); ins = instruction register,
// ac = accumulator, halted = high while stopped on ENDOP.
module processor
  import processor_pkg::*;
#(
  parameter string IMEM_FILE = "ins_mem.mem",
  parameter string DMEM_FILE = "data_mem.mem"
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [7:0]  ins,
  output logic [15:0] ac,
  output logic        halted
);

  logic [INS_W-1:0]  imem [MEM_DEPTH];
  logic [DATA_W-1:0] dmem [MEM_DEPTH];

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INS_W-1:0]   ir_q, ir_d;
  logic [ADDR_W-1:0]  opr_q, opr_d;
  logic [DATA_W-1:0]  ac_q, ac_d;
  logic [DATA_W-1:0]  r_q, r_d;
  logic               z_q, z_d;
  logic               halted_q, halted_d;

  logic [INS_W-1:0]   imem_byte_c;
  logic [DATA_W-1:0]  dmem_rdata_c;
  logic               dmem_we_c;
  logic [DATA_W-1:0]  alu_result_c;
  logic               alu_zero_c;

  assign imem_byte_c  = imem[pc_q];
  assign dmem_rdata_c = dmem[opr_q];

  processor_alu u_alu (
    .ac_i     (ac_q),
    .r_i      (r_q),
    .op_i     (ir_q),
    .result_c (alu_result_c),
    .zero_c   (alu_zero_c)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_FETCH;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH:   state_d = is_two_byte(imem_byte_c) ? ST_OPERAND : ST_EXEC;
      ST_OPERAND: state_d = ST_EXEC;
      ST_EXEC:    state_d = (ir_q == OP_ENDOP) ? ST_HALT : ST_FETCH;
      default:    state_d = ST_HALT;
    endcase
  end

  // Datapath updates per state; HALT leaves every register as is.
  always_comb begin
    pc_d      = pc_q;
    ir_d      = ir_q;
    opr_d     = opr_q;
    ac_d      = ac_q;
    r_d       = r_q;
    z_d       = z_q;
    dmem_we_c = 1'b0;
    case (state_q)
      ST_FETCH: begin
        ir_d = imem_byte_c;
        pc_d = pc_q + ADDR_W'(1);
      end
      ST_OPERAND: begin
        opr_d = imem_byte_c;
        pc_d  = pc_q + ADDR_W'(1);
      end
      ST_EXEC: begin
        case (ir_q)
          OP_LOADI: begin
            ac_d = DATA_W'(opr_q);
            z_d  = (opr_q == '0);
          end
          OP_LOAD: begin
            ac_d = dmem_rdata_c;
            z_d  = (dmem_rdata_c == '0);
          end
          OP_STORE: dmem_we_c = 1'b1;
          OP_MOVR:  r_d = ac_q;
          OP_MOVAC, OP_ADD, OP_SUB, OP_MUL, OP_INC, OP_DEC: begin
            ac_d = alu_result_c;
            z_d  = alu_zero_c;
          end
          OP_JMP:   pc_d = opr_q;
          OP_JMPZ:  if (z_q)  pc_d = opr_q;
          OP_JMPNZ: if (!z_q) pc_d = opr_q;
          default:  ;
        endcase
      end
      default: ;
    endcase
    halted_d = (state_d == ST_HALT);
  end

  // Architectural registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= '0;
      ir_q     <= '0;
      opr_q    <= '0;
      ac_q     <= '0;
      r_q      <= '0;
      z_q      <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      opr_q    <= opr_d;
      ac_q     <= ac_d;
      r_q      <= r_d;
      z_q      <= z_d;
      halted_q <= halted_d;
    end
  end

  // Data RAM write port; reset forces FETCH so an aborted STORE never writes.
  always_ff @(posedge clk) begin
    if (dmem_we_c) dmem[opr_q] <= ac_q;
  end

  assign ins    = ir_q;
  assign ac     = ac_q;
  assign halted = halted_q;

endmodule

// File: tb/tb_processor.sv
// Directed-vector bench for the accumulator processor.
module tb_processor;

  logic        clk;
  logic        rst_n;
  logic [7:0]  ins;
  logic [15:0] ac;
  logic        halted;

  int n_checks = 0;
  int n_pass   = 0;

  processor #(
    .IMEM_FILE (""),
    .DMEM_FILE ("")
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ins    (ins),
    .ac     (ac),
    .halted (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else             n_pass++;
  endtask

  task automatic put(input int a, input logic [7:0] v);
    dut.imem[a] = v;
  endtask

  // Assert reset and blank the instruction ROM (all NOP).
  task automatic reset_on();
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 256; i++) dut.imem[i] = 8'd0;
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Advance n rising edges and settle just after the last one.
  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;

    // LOADI 7; MOVR; LOADI 6; MUL; ENDOP
    reset_on();
    put(0, 8'd1); put(1, 8'd7); put(2, 8'd4); put(3, 8'd1); put(4, 8'd6);
    put(5, 8'd8); put(6, 8'd28);
    chk("rst_ins", 32'(ins), 32'd0);
    chk("rst_ac", 32'(ac), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_pc", 32'(dut.pc_q), 32'd0);
    chk("rst_z", 32'(dut.z_q), 32'd0);
    release_rst();
    run(1);  chk("mul_fetch_ins", 32'(ins), 32'd1);
    run(1);  chk("mul_operand_ins", 32'(ins), 32'd1);
    run(1);  chk("mul_loadi_ac", 32'(ac), 32'd7);
    run(8);  chk("mul_endop_ins", 32'(ins), 32'd28);
             chk("mul_exec_not_halted", 32'(halted), 32'd0);
    run(2);  chk("mul_ac", 32'(ac), 32'd42);
             chk("mul_ins", 32'(ins), 32'd28);
             chk("mul_halted", 32'(halted), 32'd1);

    // LOADI FF; MOVR; LOADI 0; SUB; STORE 5; LOADI 0; LOAD 5; ENDOP
    reset_on();
    put(0, 8'd1); put(1, 8'hFF); put(2, 8'd4); put(3, 8'd1); put(4, 8'd0);
    put(5, 8'd7); put(6, 8'd3); put(7, 8'd5); put(8, 8'd1); put(9, 8'd0);
    put(10, 8'd2); put(11, 8'd5); put(12, 8'd28);
    release_rst();
    run(10); chk("sub_ac", 32'(ac), 32'hFF01);
             chk("sub_z", 32'(dut.z_q), 32'd0);
    run(3);  chk("store_dmem5", 32'(dut.dmem[5]), 32'hFF01);
    run(3);  chk("loadi0_ac", 32'(ac), 32'd0);
             chk("loadi0_z", 32'(dut.z_q), 32'd1);
    run(3);  chk("load_ac", 32'(ac), 32'hFF01);
             chk("load_z", 32'(dut.z_q), 32'd0);
    run(2);  chk("sub_halted", 32'(halted), 32'd1);
    // Idle in HALT: nothing may move.
    run(100);
    chk("idle_ins", 32'(ins), 32'd28);
    chk("idle_ac", 32'(ac), 32'hFF01);
    chk("idle_pc", 32'(dut.pc_q), 32'd13);
    chk("idle_dmem5", 32'(dut.dmem[5]), 32'hFF01);
    chk("idle_halted", 32'(halted), 32'd1);

    // LOADI 3; DEC; JMPNZ 2; ENDOP
    reset_on();
    put(0, 8'd1); put(1, 8'd3); put(2, 8'd10); put(3, 8'd13); put(4, 8'd2);
    put(5, 8'd28);
    release_rst();
    run(5);  chk("loop_dec1_ac", 32'(ac), 32'd2);
             chk("loop_dec1_z", 32'(dut.z_q), 32'd0);
    run(3);  chk("loop_jmp_pc", 32'(dut.pc_q), 32'd2);
    run(10); chk("loop_end_ac", 32'(ac), 32'd0);
             chk("loop_end_z", 32'(dut.z_q), 32'd1);
             chk("loop_fallthru_pc", 32'(dut.pc_q), 32'd5);
    run(2);  chk("loop_ins", 32'(ins), 32'd28);
             chk("loop_halted", 32'(halted), 32'd1);

    // ADD/INC/MOVAC/JMPZ taken/JMPNZ taken
    reset_on();
    put(0, 8'd1); put(1, 8'd5); put(2, 8'd4); put(3, 8'd6); put(4, 8'd9);
    put(5, 8'd4); put(6, 8'd1); put(7, 8'd0); put(8, 8'd12); put(9, 8'd12);
    put(10, 8'd28); put(12, 8'd5); put(13, 8'd13); put(14, 8'd17);
    put(15, 8'd28); put(17, 8'd6); put(18, 8'd28);
    release_rst();
    run(7);  chk("add_ac", 32'(ac), 32'd10);
    run(2);  chk("inc_ac", 32'(ac), 32'd11);
    run(5);  chk("loadi_zero_z", 32'(dut.z_q), 32'd1);
    run(3);  chk("jmpz_pc", 32'(dut.pc_q), 32'd12);
    run(2);  chk("movac_ac", 32'(ac), 32'd11);
             chk("movac_z", 32'(dut.z_q), 32'd0);
    run(3);  chk("jmpnz_pc", 32'(dut.pc_q), 32'd17);
    run(2);  chk("add2_ac", 32'(ac), 32'd22);
    run(2);  chk("alu_halted", 32'(halted), 32'd1);

    // LOADI 0x55; STORE 9; ENDOP -- seeds DMEM[9]
    reset_on();
    put(0, 8'd1); put(1, 8'h55); put(2, 8'd3); put(3, 8'd9); put(4, 8'd28);
    release_rst();
    run(8);  chk("seed_dmem9", 32'(dut.dmem[9]), 32'h55);
             chk("seed_halted", 32'(halted), 32'd1);

    // LOADI 0x12; STORE 9; ENDOP with reset during the STORE operand cycle
    reset_on();
    put(0, 8'd1); put(1, 8'h12); put(2, 8'd3); put(3, 8'd9); put(4, 8'd28);
    release_rst();
    run(4);  chk("abort_pre_ins", 32'(ins), 32'd3);
             chk("abort_pre_state", 32'(dut.state_q), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_ins", 32'(ins), 32'd0);
    chk("abort_pc", 32'(dut.pc_q), 32'd0);
    chk("abort_ac", 32'(ac), 32'd0);
    run(2);  chk("abort_dmem9", 32'(dut.dmem[9]), 32'h55);
    release_rst();
    run(3);  chk("restart_ac", 32'(ac), 32'h12);
    run(5);  chk("restart_dmem9", 32'(dut.dmem[9]), 32'h12);
             chk("restart_halted", 32'(halted), 32'd1);

    // Undefined opcode 200 then ENDOP
    reset_on();
    put(0, 8'd200); put(1, 8'd28);
    release_rst();
    run(1);  chk("undef_ins", 32'(ins), 32'd200);
    run(1);  chk("undef_ac", 32'(ac), 32'd0);
             chk("undef_pc", 32'(dut.pc_q), 32'd1);
    run(1);  chk("undef_endop_c3", 32'(ins), 32'd28);
             chk("undef_not_halted", 32'(halted), 32'd0);
    run(1);  chk("undef_halted", 32'(halted), 32'd1);

    // PC wrap: JMP 254; INC at 254; LOADI at 255 takes operand from address 0
    reset_on();
    put(0, 8'd11); put(1, 8'd254); put(2, 8'd28); put(254, 8'd9); put(255, 8'd1);
    release_rst();
    run(3);  chk("wrap_jmp_pc", 32'(dut.pc_q), 32'd254);
    run(2);  chk("wrap_inc_ac", 32'(ac), 32'd1);
    run(3);  chk("wrap_loadi_ac", 32'(ac), 32'd11);
             chk("wrap_pc", 32'(dut.pc_q), 32'd1);
    run(4);  chk("wrap_halted", 32'(halted), 32'd1);
             chk("wrap_ins", 32'(ins), 32'd28);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
